// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI command decoder / RAM controller.
package spi_ram_pkg;

   // Word layout delivered by the SPI slave: [9:8] command, [7:0] payload.
   localparam int RX_WIDTH    = 10;
   localparam int DATA_WIDTH  = 8;
   localparam int CMD_MSB     = 9;
   localparam int CMD_LSB     = 8;
   localparam int PAYLOAD_MSB = 7;
   localparam int PAYLOAD_LSB = 0;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WR_READY = 2'b01,
      RD_READY = 2'b10,
      TX_HOLD  = 2'b11
   } state_e;

   // Extract the command field from a received word.
   function automatic cmd_e get_cmd(input logic [RX_WIDTH-1:0] word);
      return cmd_e'(word[CMD_MSB:CMD_LSB]);
   endfunction

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Word-level link between the SPI slave (master side) and the RAM controller.
interface spi_ram_ctrl_if;
   import spi_ram_pkg::*;

   logic [RX_WIDTH-1:0]   rx_data;
   logic                  rx_valid;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  err;

   // SPI slave: delivers received words, consumes read data.
   modport master (
      output rx_data,
      output rx_valid,
      input  tx_data,
      input  tx_valid,
      input  err
   );

   // RAM controller: decodes words, returns read data.
   modport slave (
      input  rx_data,
      input  rx_valid,
      output tx_data,
      output tx_valid,
      output err
   );

endinterface

// File: rtl/spi_ram_ctrl_sp_ram.sv
// Single-port synchronous RAM, one-cycle read latency, array not reset.
module sp_ram
   import spi_ram_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int WIDTH     = DATA_WIDTH
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic                 we,
   input  logic [ADDR_SIZE-1:0] addr,
   input  logic [WIDTH-1:0]     din,
   output logic [WIDTH-1:0]     dout
);

   logic [WIDTH-1:0] r_mem [MEM_DEPTH];

   // Write when enabled with we, otherwise register the addressed word.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            r_mem[addr] <= din;
         end else begin
            dout <= r_mem[addr];
         end
      end
   end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder and RAM controller downstream of the SPI slave.
// Tracks protocol order with a small FSM, keeps independent write/read
// address registers and returns read data with a registered tx handshake.
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,   // 2**ADDR_SIZE must equal MEM_DEPTH, ADDR_SIZE <= 8
   parameter int AUTO_INC  = 0
) (
   input  logic           clk,
   input  logic           rst,
   spi_ram_ctrl_if.slave  bus
);

   state_e                r_state;
   state_e                w_state_next;
   state_e                w_base_state;
   cmd_e                  w_cmd;

   logic [ADDR_SIZE-1:0]  r_wr_addr;
   logic [ADDR_SIZE-1:0]  r_rd_addr;
   logic [ADDR_SIZE-1:0]  w_payload_addr;

   logic                  w_wr_addr_ld;
   logic                  w_wr_data;
   logic                  w_rd_addr_ld;
   logic                  w_rd_data;
   logic                  w_violation;

   logic                  w_ram_en;
   logic                  w_ram_we;
   logic [ADDR_SIZE-1:0]  w_ram_addr;
   logic [DATA_WIDTH-1:0] w_ram_dout;

   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_tx_valid;
   logic                  r_err;
   logic                  r_rd_pending;   // RAM read issued last edge, data lands now
   logic                  r_clr_pending;  // command arrived on the load edge, drop tx_valid next

   assign w_cmd          = get_cmd(bus.rx_data);
   assign w_payload_addr = bus.rx_data[ADDR_SIZE-1:0];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and command decode; TX_HOLD behaves like RD_READY once a word arrives.
   always_comb begin
      w_state_next = r_state;
      w_wr_addr_ld = 1'b0;
      w_wr_data    = 1'b0;
      w_rd_addr_ld = 1'b0;
      w_rd_data    = 1'b0;
      w_violation  = 1'b0;
      w_base_state = (r_state == TX_HOLD) ? RD_READY : r_state;
      if (bus.rx_valid) begin
         w_state_next = w_base_state;
         case (w_cmd)
            CMD_WR_ADDR: begin
               w_wr_addr_ld = 1'b1;
               w_state_next = WR_READY;
            end
            CMD_RD_ADDR: begin
               w_rd_addr_ld = 1'b1;
               w_state_next = RD_READY;
            end
            CMD_WR_DATA: begin
               if (w_base_state == WR_READY) begin
                  w_wr_data = 1'b1;
               end else begin
                  w_violation = 1'b1;
               end
            end
            CMD_RD_DATA: begin
               if (w_base_state == RD_READY) begin
                  w_rd_data    = 1'b1;
                  w_state_next = TX_HOLD;
               end else begin
                  w_violation = 1'b1;
               end
            end
            default: begin
               w_violation = 1'b1;
            end
         endcase
      end
   end

   // Address registers: load on address commands, optional post-increment (wraps naturally).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_addr <= '0;
         r_rd_addr <= '0;
      end else begin
         if (w_wr_addr_ld) begin
            r_wr_addr <= w_payload_addr;
         end else if (w_wr_data && (AUTO_INC != 0)) begin
            r_wr_addr <= r_wr_addr + 1'b1;
         end
         if (w_rd_addr_ld) begin
            r_rd_addr <= w_payload_addr;
         end else if (w_rd_data && (AUTO_INC != 0)) begin
            r_rd_addr <= r_rd_addr + 1'b1;
         end
      end
   end

   // One access per accepted data command; address mux picks the active direction.
   assign w_ram_en   = w_wr_data | w_rd_data;
   assign w_ram_we   = w_wr_data;
   assign w_ram_addr = w_wr_data ? r_wr_addr : r_rd_addr;

   sp_ram #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_SIZE (ADDR_SIZE),
      .WIDTH     (DATA_WIDTH)
   ) u_ram (
      .clk  (clk),
      .en   (w_ram_en),
      .we   (w_ram_we),
      .addr (w_ram_addr),
      .din  (bus.rx_data[PAYLOAD_MSB:PAYLOAD_LSB]),
      .dout (w_ram_dout)
   );

   // Output registers: load read data one edge after the RAM read; any word drops tx_valid,
   // but a word coinciding with the load edge drops it one edge later instead.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_data     <= '0;
         r_tx_valid    <= 1'b0;
         r_err         <= 1'b0;
         r_rd_pending  <= 1'b0;
         r_clr_pending <= 1'b0;
      end else begin
         r_err        <= w_violation;
         r_rd_pending <= w_rd_data;
         if (r_rd_pending) begin
            r_tx_data     <= w_ram_dout;
            r_tx_valid    <= 1'b1;
            r_clr_pending <= bus.rx_valid;
         end else if (bus.rx_valid || r_clr_pending) begin
            r_tx_valid    <= 1'b0;
            r_clr_pending <= 1'b0;
         end
      end
   end

   assign bus.tx_data  = r_tx_data;
   assign bus.tx_valid = r_tx_valid;
   assign bus.err      = r_err;

endmodule
